// File: rtl/spin_chunk_streamer.sv
// Pops one spin vector from the spin FIFO and streams it as NUM_CHUNKS chunks,
// LSB chunk first, with back-to-back spins overlapping the last chunk transfer.
module spin_chunk_streamer #(
  parameter int DATASPIN    = 256,
  parameter int CHUNK_WIDTH = 32,
  parameter int NUM_CHUNKS  = DATASPIN / CHUNK_WIDTH,
  parameter int CNT_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   spin_valid_i,
  input  logic [DATASPIN-1:0]    spin_i,
  output logic                   spin_ready_o,
  output logic                   chunk_valid_o,
  output logic [CHUNK_WIDTH-1:0] chunk_o,
  output logic [CNT_W-1:0]       chunk_idx_o,
  output logic                   chunk_last_o,
  input  logic                   chunk_ready_i,
  output logic                   busy_o,
  output logic [15:0]            spin_count_o
);

  if (DATASPIN % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("DATASPIN must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic {IDLE, STREAM} state_e;

  state_e              state_q, state_d;
  logic [DATASPIN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [15:0]         spin_count_q, spin_count_d;

  logic is_last;
  logic xfer;
  logic accept;

  // Handshakes: a spin moves when spin_valid_i & spin_ready_o, a chunk moves
  // when chunk_valid_o & chunk_ready_i; valid never depends on ready.
  assign is_last       = (idx_q == CNT_W'(NUM_CHUNKS - 1));
  assign busy_o        = (state_q == STREAM);
  assign chunk_valid_o = busy_o;
  assign chunk_last_o  = busy_o & is_last;
  assign chunk_idx_o   = idx_q;
  assign chunk_o       = shadow_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign spin_count_o  = spin_count_q;
  assign xfer          = chunk_valid_o & chunk_ready_i;

  // The STREAM term lets the next spin be popped on the last-chunk edge.
  assign spin_ready_o = ~rst_i & en_i & ~flush_i &
                        ((state_q == IDLE) | (chunk_last_o & chunk_ready_i));
  assign accept       = spin_valid_i & spin_ready_o;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    spin_count_d = spin_count_q;
    if (flush_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shadow_d = spin_i;
            idx_d    = '0;
            state_d  = STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (!is_last) begin
              idx_d = idx_q + CNT_W'(1);
            end else begin
              spin_count_d = spin_count_q + 16'd1;
              idx_d        = '0;
              if (accept) begin
                shadow_d = spin_i;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      idx_q        <= '0;
      spin_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      spin_count_q <= spin_count_d;
    end
  end

endmodule
